// File: rtl/bp_burst_to_lite_pkg.sv
// Shared types and helpers for the Burst-to-Lite gatherer and its serializer counterpart.
// No logic state lives here.
// Header layout matches the Lite header that is replayed on the output side.
package bp_burst_to_lite_pkg;

  localparam int paddr_width_lp   = 40;
  localparam int payload_width_lp = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } msg_type_e;

  typedef enum logic [2:0] {
    e_size_1, e_size_2, e_size_4, e_size_8,
    e_size_16, e_size_32, e_size_64, e_size_128
  } msg_size_e;

  typedef struct packed {
    msg_type_e                   msg_type;
    msg_size_e                   size;
    logic [paddr_width_lp-1:0]   addr;
    logic [payload_width_lp-1:0] payload;
  } hdr_t;

  typedef enum logic [1:0] {e_ready, e_data, e_send} state_e;

  // Width of a counter able to index n slots; never zero.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Number of Burst beats a message of 2^size bytes occupies; sub-beat sizes still use one beat.
  function automatic int bp_me_burst_beats(input logic [2:0] size, input int beat_bytes);
    int b;
    b = int'(32'd1 << size) / beat_bytes;
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/bp_burst_to_lite_if.sv
// Burst input (header + beat channels) and Lite output bundle.
// All three channels use ready-valid-and handshakes.
// master drives Burst and consumes Lite; slave is the converter.
interface bp_burst_to_lite_if
  import bp_burst_to_lite_pkg::*;
#(
  parameter int in_width_p  = 64,
  parameter int out_width_p = 512
);
  hdr_t                              in_msg_header;
  logic                              in_msg_header_v;
  logic                              in_msg_header_ready_and;
  logic [in_width_p-1:0]             in_msg_data;
  logic                              in_msg_data_v;
  logic                              in_msg_data_ready_and;
  logic [$bits(hdr_t)+out_width_p-1:0] out_msg;
  logic                              out_msg_v;
  logic                              out_msg_ready_and;

  modport master (
    output in_msg_header, in_msg_header_v, in_msg_data, in_msg_data_v, out_msg_ready_and,
    input  in_msg_header_ready_and, in_msg_data_ready_and, out_msg, out_msg_v
  );

  modport slave (
    input  in_msg_header, in_msg_header_v, in_msg_data, in_msg_data_v, out_msg_ready_and,
    output in_msg_header_ready_and, in_msg_data_ready_and, out_msg, out_msg_v
  );
endinterface

// File: rtl/bp_burst_to_lite_gather.sv
// Beat counter plus slot-indexed data register that assembles narrow beats into one wide word.
// Latency: a beat lands in its slot on the edge of its write strobe; done_o is combinational.
// No backpressure of its own: the caller only strobes we_i on an accepted beat.
module bp_burst_to_lite_gather
  import bp_burst_to_lite_pkg::*;
#(
  parameter int in_width_p  = 64,
  parameter int max_beats_p = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 clear_i,
  input  logic                                 we_i,
  input  logic [in_width_p-1:0]                data_i,
  input  logic [safe_clog2(max_beats_p)-1:0]   last_cnt_i,
  output logic [in_width_p*max_beats_p-1:0]    data_o,
  output logic                                 done_o
);
  localparam int cnt_width_lp = safe_clog2(max_beats_p);

  logic [cnt_width_lp-1:0]           r_cnt;
  logic [in_width_p*max_beats_p-1:0] r_data;

  // Clear on a new message, otherwise drop each accepted beat into the next slot.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else if (clear_i) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else if (we_i) begin
      r_data[int'(r_cnt)*in_width_p +: in_width_p] <= data_i;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign data_o = r_data;
  assign done_o = we_i & (r_cnt == last_cnt_i);
endmodule

// File: rtl/bp_burst_to_lite.sv
// Gathers a Burst header plus narrow beats into one Lite message carrying wide data.
// Latency: out valid one cycle after the header (no data) or after the last beat handshake.
// One message in flight; input readies drop while a message is held until the consumer takes it.
module bp_burst_to_lite
  import bp_burst_to_lite_pkg::*;
#(
  parameter int          in_data_width_p  = 64,
  parameter int          out_data_width_p = 512,
  parameter int          payload_width_p  = payload_width_lp,
  parameter logic [15:0] payload_mask_p   = '0
) (
  input logic               clk_i,
  input logic               reset_n_i,
  bp_burst_to_lite_if.slave bus
);
  localparam int max_beats_lp = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = safe_clog2(max_beats_lp);
  localparam int in_bytes_lp  = in_data_width_p / 8;
  localparam int out_bytes_lp = out_data_width_p / 8;

  if (in_data_width_p > out_data_width_p) begin : g_err_narrow_out
    $error("in_data_width_p must not exceed out_data_width_p");
  end
  if (out_data_width_p % in_data_width_p != 0) begin : g_err_multiple
    $error("out_data_width_p must be a multiple of in_data_width_p");
  end
  if (payload_width_p != payload_width_lp) begin : g_err_payload
    $error("payload_width_p must match the header payload field");
  end

  state_e                      r_state, w_state_n;
  hdr_t                        r_hdr;
  logic                        w_hdr_rdy, w_data_rdy, w_out_v;
  logic                        w_hdr_hs, w_data_hs, w_done;
  logic                        w_has_data_in, w_has_data;
  logic [cnt_width_lp-1:0]     w_last_cnt;
  logic [out_data_width_p-1:0] w_asm, w_data;
  logic [7:0]                  w_size_mask;

  assign w_hdr_hs      = w_hdr_rdy & bus.in_msg_header_v;
  assign w_data_hs     = w_data_rdy & bus.in_msg_data_v;
  assign w_has_data_in = payload_mask_p[bus.in_msg_header.msg_type];
  assign w_has_data    = payload_mask_p[r_hdr.msg_type];
  assign w_last_cnt    = cnt_width_lp'(bp_me_burst_beats(r_hdr.size, in_bytes_lp) - 1);

  bp_burst_to_lite_gather #(
    .in_width_p  (in_data_width_p),
    .max_beats_p (max_beats_lp)
  ) u_gather (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (w_hdr_hs),
    .we_i       (w_data_hs),
    .data_i     (bus.in_msg_data),
    .last_cnt_i (w_last_cnt),
    .data_o     (w_asm),
    .done_o     (w_done)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_ready;
    else            r_state <= w_state_n;
  end

  // Capture the header on acceptance; it is replayed unchanged on the Lite side.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)    r_hdr <= '0;
    else if (w_hdr_hs) r_hdr <= bus.in_msg_header;
  end

  // Next state and channel enables; only one channel is open in any state.
  always_comb begin
    w_state_n  = r_state;
    w_hdr_rdy  = 1'b0;
    w_data_rdy = 1'b0;
    w_out_v    = 1'b0;
    case (r_state)
      e_ready: begin
        w_hdr_rdy = 1'b1;
        if (bus.in_msg_header_v) w_state_n = w_has_data_in ? e_data : e_send;
      end
      e_data: begin
        w_data_rdy = 1'b1;
        if (w_done) w_state_n = e_send;
      end
      e_send: begin
        w_out_v = 1'b1;
        if (bus.out_msg_ready_and) w_state_n = e_ready;
      end
      default: w_state_n = e_ready;
    endcase
  end

  // Small messages are replicated by folding each output byte onto the low 2^size-byte region.
  assign w_size_mask = 8'((32'd1 << r_hdr.size) - 32'd1);
  always_comb begin
    w_data = '0;
    if (w_has_data) begin
      for (int i = 0; i < out_bytes_lp; i++) begin
        w_data[8*i +: 8] = w_asm[8*(i & int'(w_size_mask)) +: 8];
      end
    end
  end

  // Reset forces every handshake output low even though the FSM rests in e_ready.
  assign bus.in_msg_header_ready_and = w_hdr_rdy & reset_n_i;
  assign bus.in_msg_data_ready_and   = w_data_rdy & reset_n_i;
  assign bus.out_msg_v               = w_out_v & reset_n_i;
  assign bus.out_msg                 = (w_out_v & reset_n_i) ? {r_hdr, w_data} : '0;

  a_size_fits: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    w_hdr_hs |-> ((32'd1 << bus.in_msg_header.size) <= 32'(out_bytes_lp)));
endmodule

// File: tb/tb_bp_burst_to_lite.sv
`timescale 1ns/1ps
module tb_bp_burst_to_lite;
  import bp_burst_to_lite_pkg::*;

  localparam int          IN_W  = 64;
  localparam int          OUT_W = 512;
  localparam int          MSG_W = $bits(hdr_t) + OUT_W;
  localparam logic [15:0] MASK  = 16'h000A; // wr and uc_wr carry data

  typedef struct {
    msg_type_e   t;
    msg_size_e   s;
    logic [39:0] addr;
    logic [63:0] base;
    int          exp_beats;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_burst_to_lite_if #(.in_width_p(IN_W), .out_width_p(OUT_W)) bus ();

  bp_burst_to_lite #(
    .in_data_width_p  (IN_W),
    .out_data_width_p (OUT_W),
    .payload_width_p  (payload_width_lp),
    .payload_mask_p   (MASK)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  int msgs_seen = 0;
  logic [MSG_W-1:0] exp_q[$];
  logic [MSG_W-1:0] mon_exp;
  vec_t vecs[8];

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted Lite message must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.in_msg_data_v && bus.in_msg_data_ready_and) beats_seen++;
    if (rst_n && bus.out_msg_v && bus.out_msg_ready_and) begin
      msgs_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_msg: got %h expected none", bus.out_msg);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out_msg !== mon_exp) begin
          errors++;
          $display("FAIL lite_msg: got %h expected %h", bus.out_msg, mon_exp);
        end
      end
    end
  end

  function automatic hdr_t mk_hdr(input msg_type_e t, input msg_size_e s, input logic [39:0] a);
    hdr_t h;
    h.msg_type = t;
    h.size     = s;
    h.addr     = a;
    h.payload  = a[15:0] ^ 16'h5A5A;
    return h;
  endfunction

  function automatic int model_beats(input hdr_t h);
    int bytes;
    bytes = 1 << h.size;
    if (!MASK[h.msg_type]) return 0;
    return (bytes < 8) ? 1 : bytes / 8;
  endfunction

  // Beat k carries base+k; the 2^size-byte region is repeated bit by bit across the output.
  function automatic logic [OUT_W-1:0] model_data(input hdr_t h, input logic [63:0] base);
    logic [OUT_W-1:0] full;
    logic [OUT_W-1:0] d;
    int rbits;
    full = '0;
    d    = '0;
    if (!MASK[h.msg_type]) return d;
    for (int k = 0; k < model_beats(h); k++) full[64*k +: 64] = base + 64'(k);
    rbits = (1 << h.size) * 8;
    for (int b = 0; b < OUT_W; b++) d[b] = full[b % rbits];
    return d;
  endfunction

  // All drive tasks start and end #1 after a rising edge.
  task automatic send_hdr(input hdr_t h, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    bus.in_msg_header   = h;
    bus.in_msg_header_v = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_msg_header_ready_and) ok = 1;
      else waited++;
      @(posedge clk); #1;
    end
    bus.in_msg_header_v = 1'b0;
    if (!ok) check_bit("hdr_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_beat(input logic [63:0] d, input int gap);
    bit ok;
    ok = 0;
    bus.in_msg_data_v = 1'b0;
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    bus.in_msg_data   = d;
    bus.in_msg_data_v = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_msg_data_ready_and) ok = 1;
      @(posedge clk); #1;
    end
    bus.in_msg_data_v = 1'b0;
    if (!ok) check_bit("beat_timeout", 1'b0, 1'b1);
  endtask

  // Drives a whole message; returns with the Lite message presented but not yet consumed.
  task automatic run_msg(input hdr_t h, input logic [63:0] base, input int max_gap);
    int w;
    exp_q.push_back({h, model_data(h, base)});
    send_hdr(h, w);
    for (int k = 0; k < model_beats(h); k++) begin
      check_bit("out_v_before_last", bus.out_msg_v, 1'b0);
      send_beat(base + 64'(k), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    check_bit("out_v_latency", bus.out_msg_v, 1'b1);
    check_bit("hdr_rdy_in_send", bus.in_msg_header_ready_and, 1'b0);
    check_bit("data_rdy_in_send", bus.in_msg_data_ready_and, 1'b0);
  endtask

  task automatic wait_drained();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin @(posedge clk); #1; end
    check_int("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int b0, m0, w;
    hdr_t h;
    vecs[0] = '{e_bedrock_mem_rd,    e_size_8,  40'h80_0000_40, 64'h0,                  0};
    vecs[1] = '{e_bedrock_mem_wr,    e_size_64, 40'h00_0000_1000, 64'h0,                8};
    vecs[2] = '{e_bedrock_mem_wr,    e_size_4,  40'h00_0000_2004, 64'h0000_0000_DEAD_BEEF, 1};
    vecs[3] = '{e_bedrock_mem_wr,    e_size_16, 40'h00_0000_3010, 64'hA,                2};
    vecs[4] = '{e_bedrock_mem_uc_wr, e_size_32, 40'h00_0000_4020, 64'h1111_0000,        4};
    vecs[5] = '{e_bedrock_mem_uc_rd, e_size_64, 40'h00_0000_5000, 64'h0,                0};
    vecs[6] = '{e_bedrock_mem_wr,    e_size_1,  40'h00_0000_6001, 64'h5A,               1};
    vecs[7] = '{e_bedrock_mem_wr,    e_size_8,  40'h00_0000_7008, 64'h0123_4567_89AB_CDEF, 1};
    vecs[0].addr = 40'h00_8000_0040;

    bus.in_msg_header     = '0;
    bus.in_msg_header_v   = 1'b0;
    bus.in_msg_data       = '0;
    bus.in_msg_data_v     = 1'b0;
    bus.out_msg_ready_and = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_hdr_rdy", bus.in_msg_header_ready_and, 1'b0);
    check_bit("rst_data_rdy", bus.in_msg_data_ready_and, 1'b0);
    check_bit("rst_out_v", bus.out_msg_v, 1'b0);
    check_bit("rst_out_msg_nonzero", |bus.out_msg, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("idle_hdr_rdy", bus.in_msg_header_ready_and, 1'b1);
    check_bit("idle_data_rdy", bus.in_msg_data_ready_and, 1'b0);
    check_bit("idle_out_v", bus.out_msg_v, 1'b0);

    // Table-driven messages, back-to-back, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      b0 = beats_seen;
      run_msg(mk_hdr(vecs[i].t, vecs[i].s, vecs[i].addr), vecs[i].base, 0);
      wait_drained();
      check_int("beats_accepted", beats_seen - b0, vecs[i].exp_beats);
    end

    // Sub-beat write: literal replication and no second beat accepted while held.
    bus.out_msg_ready_and = 1'b0;
    b0 = beats_seen;
    run_msg(mk_hdr(e_bedrock_mem_wr, e_size_4, 40'h9000), 64'h0000_0000_DEAD_BEEF, 0);
    checks++;
    if (bus.out_msg[OUT_W-1:0] !== {16{32'hDEAD_BEEF}}) begin
      errors++;
      $display("FAIL deadbeef_repl: got %h expected 16x deadbeef", bus.out_msg[OUT_W-1:0]);
    end
    bus.in_msg_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_msg_data_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_bit("extra_beat_rdy", bus.in_msg_data_ready_and, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_msg_data_v     = 1'b0;
    bus.out_msg_ready_and = 1'b1;
    wait_drained();
    check_int("single_beat_only", beats_seen - b0, 1);

    // Gapped 8-beat write, consumer stalls 5 cycles, next header follows immediately.
    bus.out_msg_ready_and = 1'b0;
    h = mk_hdr(e_bedrock_mem_wr, e_size_64, 40'hA000);
    run_msg(h, 64'h100, 3);
    repeat (5) begin
      @(negedge clk);
      check_bit("stall_out_v", bus.out_msg_v, 1'b1);
      check_bit("stall_hdr_rdy", bus.in_msg_header_ready_and, 1'b0);
      checks++;
      if (bus.out_msg !== {h, model_data(h, 64'h100)}) begin
        errors++;
        $display("FAIL stall_stable: got %h", bus.out_msg);
      end
      @(posedge clk); #1;
    end
    bus.out_msg_ready_and = 1'b1;
    exp_q.push_back({mk_hdr(e_bedrock_mem_rd, e_size_8, 40'hB000), {OUT_W{1'b0}}});
    send_hdr(mk_hdr(e_bedrock_mem_rd, e_size_8, 40'hB000), w);
    check_int("next_hdr_wait", w, 1);
    check_bit("next_rd_out_v", bus.out_msg_v, 1'b1);
    wait_drained();

    // Reset after 3 of 8 beats: everything drops at once, no message escapes.
    m0 = msgs_seen;
    send_hdr(mk_hdr(e_bedrock_mem_wr, e_size_64, 40'hC000), w);
    for (int k = 0; k < 3; k++) send_beat(64'h700 + 64'(k), 0);
    bus.in_msg_data   = 64'h703;
    bus.in_msg_data_v = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_bit("midrst_hdr_rdy", bus.in_msg_header_ready_and, 1'b0);
    check_bit("midrst_data_rdy", bus.in_msg_data_ready_and, 1'b0);
    check_bit("midrst_out_v", bus.out_msg_v, 1'b0);
    check_bit("midrst_out_msg_nonzero", |bus.out_msg, 1'b0);
    bus.in_msg_data_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("post_rst_hdr_rdy", bus.in_msg_header_ready_and, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check_int("no_msg_after_abort", msgs_seen - m0, 0);
    run_msg(mk_hdr(e_bedrock_mem_wr, e_size_16, 40'hD010), 64'hA, 0);
    checks++;
    if (bus.out_msg[OUT_W-1:0] !== {4{64'hB, 64'hA}}) begin
      errors++;
      $display("FAIL fresh_after_rst: got %h", bus.out_msg[OUT_W-1:0]);
    end
    wait_drained();
    check_int("msgs_after_rst", msgs_seen - m0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
